mult_test_sequencer: RTL

Self-checking test controller for the radix-4 multiplier. It steps the LFSR operand generator, latches each (x, y) pair into the multiplier, issues a start pulse and waits for completion. It checks each product against an internal reference multiply and accumulates vector and error counts. It sits between the generator and the multiplier and is the top-level run control for on-board self test.

---
 rtl/mult_test_sequencer_if.sv | 35 +++
 rtl/mult_test_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mult_test_sequencer_if.sv
// Generator, multiplier and run-status signals of the multiplier self-test sequencer.
// The sequencer takes the master modport; the generator/multiplier/host side takes slave.
interface mult_test_sequencer_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic                   gen_step;
    logic [WIDTH-1:0]       gen_x;
    logic [WIDTH-1:0]       gen_y;
    logic [WIDTH-1:0]       mul_a;
    logic [WIDTH-1:0]       mul_b;
    logic                   mul_start;
    logic                   mul_done;
    logic [2*WIDTH-1:0]     mul_product;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [15:0]            vec_count;
    logic [15:0]            err_count;
    logic [WIDTH-1:0]       fail_a;
    logic [WIDTH-1:0]       fail_b;
    logic                   timeout_flag;

    modport master (
        input  start, gen_x, gen_y, mul_done, mul_product,
        output gen_step, mul_a, mul_b, mul_start, busy, done, pass,
               vec_count, err_count, fail_a, fail_b, timeout_flag
    );

    modport slave (
        output start, gen_x, gen_y, mul_done, mul_product,
        input  gen_step, mul_a, mul_b, mul_start, busy, done, pass,
               vec_count, err_count, fail_a, fail_b, timeout_flag
    );
endinterface

// File: rtl/mult_test_sequencer.sv
// Self-test run control: steps the operand generator, drives the multiplier, checks each product.
// Define SEQ_TIMEOUT_EN to bound WAIT to TIMEOUT+1 cycles per vector and enable timeout_flag.
module mult_test_sequencer #(
    parameter int WIDTH       = 8,
    parameter int NUM_VECTORS = 256,
    parameter int TIMEOUT     = 31
) (
    input logic                   clk,
    input logic                   reset,
    mult_test_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, STEP, LOAD, ISSUE, WAIT, CHECK, DONE} state_t;

    state_t             state, next_state;
    logic [WIDTH-1:0]   mul_a, mul_b, fail_a, fail_b;
    logic [2*WIDTH-1:0] result, ref_product;
    logic [15:0]        vec_count, err_count;
    logic               fail_seen, timeout_flag, wait_expired;
    logic               gen_step, mul_start, clear_run, load, capture;
    logic               record, record_bad, last_vec;

    assign ref_product = (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);
    assign last_vec    = (int'(vec_count) + 1) == NUM_VECTORS;

`ifdef SEQ_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_count;

    assign wait_expired = (wait_count == WAIT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset)               wait_count <= '0;
        else if (state == ISSUE) wait_count <= '0;
        else if (state == WAIT)  wait_count <= wait_count + 1'b1;
    end

    // A vector is only recorded from WAIT when it hung.
    always_ff @(posedge clk) begin
        if (reset)                         timeout_flag <= 1'b0;
        else if (clear_run)                timeout_flag <= 1'b0;
        else if (record && state == WAIT)  timeout_flag <= 1'b1;
    end
`else
    assign wait_expired = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        gen_step   = 1'b0;
        mul_start  = 1'b0;
        clear_run  = 1'b0;
        load       = 1'b0;
        capture    = 1'b0;
        record     = 1'b0;
        record_bad = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    clear_run  = 1'b1;
                    next_state = STEP;
                end
            end
            STEP: begin
                gen_step   = 1'b1;
                next_state = LOAD;
            end
            LOAD: begin
                load       = 1'b1;
                next_state = ISSUE;
            end
            ISSUE: begin
                mul_start  = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (bus.mul_done) begin
                    capture    = 1'b1;
                    next_state = CHECK;
                end else if (wait_expired) begin
                    record     = 1'b1;
                    record_bad = 1'b1;
                    next_state = last_vec ? DONE : STEP;
                end
            end
            CHECK: begin
                record     = 1'b1;
                record_bad = (result != ref_product);
                next_state = last_vec ? DONE : STEP;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mul_a     <= '0;
            mul_b     <= '0;
            vec_count <= '0;
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
            fail_seen <= 1'b0;
        end else begin
            if (clear_run) begin
                vec_count <= '0;
                err_count <= '0;
                fail_a    <= '0;
                fail_b    <= '0;
                fail_seen <= 1'b0;
            end
            if (load) begin
                mul_a <= bus.gen_x;
                mul_b <= bus.gen_y;
            end
            if (record) begin
                vec_count <= vec_count + 16'd1;
                if (record_bad) begin
                    if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                    if (!fail_seen) begin
                        fail_seen <= 1'b1;
                        fail_a    <= mul_a;
                        fail_b    <= mul_b;
                    end
                end
            end
        end
    end

    // NOTE: no reset on the result register; WAIT always writes it before CHECK reads it.
    always_ff @(posedge clk) begin
        if (capture) result <= bus.mul_product;
    end

    assign bus.gen_step     = gen_step;
    assign bus.mul_start    = mul_start;
    assign bus.mul_a        = mul_a;
    assign bus.mul_b        = mul_b;
    assign bus.busy         = (state != IDLE) && (state != DONE);
    assign bus.done         = (state == DONE);
    assign bus.pass         = (state == DONE) && (err_count == 16'd0);
    assign bus.vec_count    = vec_count;
    assign bus.err_count    = err_count;
    assign bus.fail_a       = fail_a;
    assign bus.fail_b       = fail_b;
    assign bus.timeout_flag = timeout_flag;
endmodule
